// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding, the frame geometry (data bits per
// frame, oversampling ratio) and the mid-bit sample positions. The
// transmitter picks up DATA_BITS from here as well.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Oversample counts at which the line is sampled; the bit is decided at HI.
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;

    // 2-of-3 vote used for every bit decision.
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input, plus a
// falling-edge detector on the synchronized line.
// Ports:
//   clk, rst  - system clock, asynchronous active-low reset
//   rxd       - raw serial line (idle high)
//   rxs       - synchronized line
//   fall      - high for one cycle when rxs goes 1 -> 0
// All flops reset to 1 so that a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            rxs  <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rxd;
            rxs  <= meta;
            prev <= rxs;
        end
    end

    // A line held low (break) keeps prev low, so a new edge needs rxs high first.
    assign fall = prev & ~rxs;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, 16x oversampling with 2-of-3 majority
// bit decisions, false-start rejection, framing/overrun flags and a
// one-entry holding register with a valid/ack handshake.
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   rxd          - serial input, idle high, asynchronous to clk
//   rx_ack       - consumer took rx_data; clears rx_valid
//   rx_data      - last good byte received
//   rx_valid     - level, rx_data holds an unread byte
//   rx_busy      - a frame is in progress (state != IDLE)
//   frame_err    - one-cycle pulse, stop bit sampled low
//   overrun_err  - one-cycle pulse, good byte dropped because rx_valid was high
// Handshake: rx_valid rises on the clock after a good stop decision and
// stays high until a cycle with rx_ack high; rx_ack while rx_valid is low
// does nothing. An ack in the same cycle as a new good byte retires the
// old byte and accepts the new one.
// Only OVERSAMPLE = 16 is supported.
module uart_receiver #(
    parameter int CLKS_PER_SAMPLE = 2,
    parameter int OVERSAMPLE      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rxd,
    input  logic                           rx_ack,
    output logic [uart_pkg::DATA_BITS-1:0] rx_data,
    output logic                           rx_valid,
    output logic                           rx_busy,
    output logic                           frame_err,
    output logic                           overrun_err
);

    import uart_pkg::*;

    localparam int TICK_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS);

    rx_state_t             state;
    rx_state_t             next_state;
    logic                  rxs;
    logic                  start_edge;
    logic [TICK_W-1:0]     tick_cnt;
    logic                  tick;
    logic [SAMP_W-1:0]     samp_cnt;
    logic [SAMP_W-1:0]     samp_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  sample_lo;
    logic                  sample_mid;
    logic                  decide;
    logic                  bit_val;
    logic                  last_bit;
    logic                  load_byte;
    logic                  raise_overrun;
    logic                  raise_frame;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .rxs  (rxs),
        .fall (start_edge)
    );

    // "Count n" is the value the sample counter takes on the n-th tick of a
    // bit, so the stop decision lands (9*16+9)*CLKS_PER_SAMPLE clk after the
    // detected start edge.
    assign tick      = (tick_cnt == TICK_W'(CLKS_PER_SAMPLE - 1));
    assign samp_next = (samp_cnt == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
    assign decide    = tick && (samp_next == SAMP_W'(SAMPLE_HI));
    // Third sample is taken live at the decision tick.
    assign bit_val   = majority3({rxs, sample_mid, sample_lo});
    assign last_bit  = (bit_idx == IDX_W'(DATA_BITS - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. STOP leaves at mid-stop-bit so a back-to-back
    // start edge is seen.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_edge) next_state = START;
            START:   if (decide) next_state = bit_val ? IDLE : DATA;
            DATA:    if (decide && last_bit) next_state = STOP;
            STOP:    if (decide) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        rx_busy       = (state != IDLE);
        load_byte     = 1'b0;
        raise_overrun = 1'b0;
        raise_frame   = 1'b0;
        if (state == STOP && decide) begin
            if (!bit_val) begin
                raise_frame = 1'b1;
            end else if (rx_valid && !rx_ack) begin
                raise_overrun = 1'b1;
            end else begin
                load_byte = 1'b1;
            end
        end
    end

    // Bit timing and shift register. Counters are held at zero in IDLE,
    // which also clears them on entry to START.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            sample_lo  <= 1'b0;
            sample_mid <= 1'b0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
            samp_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                samp_cnt <= samp_next;
                if (samp_next == SAMP_W'(SAMPLE_LO))  sample_lo  <= rxs;
                if (samp_next == SAMP_W'(SAMPLE_MID)) sample_mid <= rxs;
            end
            if (state == DATA && decide) begin
                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
        end
    end

    // Holding register and error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= raise_frame;
            overrun_err <= raise_overrun;
            if (load_byte) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. Drives 8N1 frames onto rxd
// (32 clk per bit unless stated), checks a table of frame outcomes,
// several hand-written timing sequences, and a randomized run against
// a byte-level reference model.
// Timing reference: rxd is driven 1 ns after a falling clock edge; with
// the 2-flop synchronizer the receiver sees the start edge 2 clk later,
// so a good byte shows rx_valid 2 + 307 = 309 clk after rxd falls.
module tb_uart_receiver;

    localparam int BIT_CLKS = 32;
    localparam int NVEC     = 8;
    localparam int NRAND    = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int oerr_cnt = 0;
    int busy_cnt = 0;
    int fb, ob, bb;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLKS_PER_SAMPLE (2),
        .OVERSAMPLE      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    // Pulse / activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_err)   ferr_cnt++;
        if (overrun_err) oerr_cnt++;
        if (rx_busy)     busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int blen);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            step(blen);
        end
        rxd = 1'b1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic       stop_bit;
        int         gap;
        logic       ack;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
        int         exp_oerr;
    } vec_t;

    vec_t vecs[NVEC];

    // Reference model state for the random run
    logic       model_valid;
    logic [7:0] model_data;
    logic [7:0] exp_q[$];

    initial begin
        logic [7:0] d;
        logic       stop_ok;
        int         blen;
        int         lat;

        // Outcome table; gap 0 means the next frame starts the cycle this one ends.
        vecs[0] = '{8'hA5, 1'b1, 0, 1'b1, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b1, 0, 1'b1, 1'b1, 8'h3C, 0, 0};
        vecs[2] = '{8'h55, 1'b0, 8, 1'b0, 1'b0, 8'h3C, 1, 0};
        vecs[3] = '{8'h11, 1'b1, 0, 1'b0, 1'b1, 8'h11, 0, 0};
        vecs[4] = '{8'h22, 1'b1, 0, 1'b0, 1'b1, 8'h11, 0, 1};
        vecs[5] = '{8'h00, 1'b1, 0, 1'b1, 1'b1, 8'h11, 0, 1};
        vecs[6] = '{8'hFF, 1'b1, 0, 1'b0, 1'b1, 8'hFF, 0, 0};
        vecs[7] = '{8'h80, 1'b0, 8, 1'b1, 1'b1, 8'hFF, 1, 0};

        // ---- reset values ----
        rst    = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        step(3);
        check("rst_data",  32'(rx_data), 0);
        check("rst_valid", 32'(rx_valid), 0);
        check("rst_busy",  32'(rx_busy), 0);
        check("rst_ferr",  32'(frame_err), 0);
        check("rst_oerr",  32'(overrun_err), 0);
        rst = 1'b1;
        step(5);

        // ---- latency and rx_busy rise ----
        fork
            send_frame(8'hA5, 1'b1, BIT_CLKS);
            begin
                step(2);
                check("busy_pre", 32'(rx_busy), 0);
                step(1);
                check("busy_rise", 32'(rx_busy), 1);
                lat = 3;
                while (!rx_valid && lat < 400) begin
                    step(1);
                    lat++;
                end
                check("latency", lat, 309);
                check("lat_data", 32'(rx_data), 'hA5);
                check("lat_ferr", 32'(frame_err), 0);
            end
        join
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        check("ack_clear", 32'(rx_valid), 0);
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        check("ack_idle_valid", 32'(rx_valid), 0);
        check("ack_idle_data", 32'(rx_data), 'hA5);
        step(4);

        // ---- table-driven frames ----
        for (int i = 0; i < NVEC; i++) begin
            fb = ferr_cnt;
            ob = oerr_cnt;
            fork
                send_frame(vecs[i].din, vecs[i].stop_bit, BIT_CLKS);
                begin
                    step(312);
                    check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
                    check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
                    check($sformatf("vec%0d_ferr", i), ferr_cnt - fb, vecs[i].exp_ferr);
                    check($sformatf("vec%0d_oerr", i), oerr_cnt - ob, vecs[i].exp_oerr);
                    if (vecs[i].ack) begin
                        rx_ack = 1'b1;
                        step(1);
                        rx_ack = 1'b0;
                        check($sformatf("vec%0d_ack", i), 32'(rx_valid), 0);
                    end
                end
            join
            step(vecs[i].gap);
        end
        step(4);

        // ---- frame_err pulse timing and width ----
        fork
            send_frame(8'h55, 1'b0, BIT_CLKS);
            begin
                step(308);
                check("ferr_early", 32'(frame_err), 0);
                step(1);
                check("ferr_pulse", 32'(frame_err), 1);
                step(1);
                check("ferr_width", 32'(frame_err), 0);
                check("ferr_valid", 32'(rx_valid), 0);
            end
        join
        step(8);

        // ---- glitch: 6 clk low is a false start ----
        fb = ferr_cnt;
        ob = oerr_cnt;
        bb = busy_cnt;
        rxd = 1'b0;
        step(6);
        rxd = 1'b1;
        step(20);
        check("glitch_busy_seen", 32'((busy_cnt - bb) > 0), 1);
        check("glitch_idle", 32'(rx_busy), 0);
        check("glitch_valid", 32'(rx_valid), 0);
        check("glitch_errs", (ferr_cnt - fb) + (oerr_cnt - ob), 0);
        step(4);

        // ---- ack lands in the same cycle as a new good byte ----
        send_frame(8'h11, 1'b1, BIT_CLKS);
        step(4);
        ob = oerr_cnt;
        fork
            send_frame(8'h6E, 1'b1, BIT_CLKS);
            begin
                step(308);
                rx_ack = 1'b1;
                step(1);
                rx_ack = 1'b0;
                check("same_cyc_valid", 32'(rx_valid), 1);
                check("same_cyc_data", 32'(rx_data), 'h6E);
                check("same_cyc_oerr", oerr_cnt - ob, 0);
            end
        join
        step(4);

        // ---- reset mid-frame (during data bit 4 of 0x3C) ----
        rxd = 1'b0;
        step(BIT_CLKS);
        for (int b = 0; b < 4; b++) begin
            rxd = b[1];           // 0x3C bits 0..3 = 0,0,1,1
            step(BIT_CLKS);
        end
        rxd = 1'b1;               // bit 4
        step(10);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(rx_valid), 0);
        check("midrst_data", 32'(rx_data), 0);
        check("midrst_busy", 32'(rx_busy), 0);
        step(4);
        rst = 1'b1;
        step(40);
        check("no_resume_busy", 32'(rx_busy), 0);
        check("no_resume_valid", 32'(rx_valid), 0);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        step(4);
        check("after_rst_valid", 32'(rx_valid), 1);
        check("after_rst_data", 32'(rx_data), 'h3C);
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;

        // ---- randomized frames against the byte-level model ----
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(4);
        model_valid = 1'b0;
        model_data  = 8'h00;
        for (int n = 0; n < NRAND; n++) begin
            d       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 4) != 0);
            blen    = $urandom_range(31, 33);
            fb = ferr_cnt;
            ob = oerr_cnt;
            send_frame(d, stop_ok, blen);
            step(4);
            // Model: bad stop -> framing error; good byte with an unread
            // byte pending -> overrun; otherwise the byte is accepted.
            if (!stop_ok) begin
                check("rand_ferr", ferr_cnt - fb, 1);
                check("rand_oerr", oerr_cnt - ob, 0);
            end else if (model_valid) begin
                check("rand_ferr", ferr_cnt - fb, 0);
                check("rand_oerr", oerr_cnt - ob, 1);
            end else begin
                check("rand_ferr", ferr_cnt - fb, 0);
                check("rand_oerr", oerr_cnt - ob, 0);
                model_valid = 1'b1;
                model_data  = d;
                exp_q.push_back(d);
            end
            check("rand_valid", 32'(rx_valid), 32'(model_valid));
            check("rand_data", 32'(rx_data), 32'(model_data));
            if ($urandom_range(0, 1) == 1) begin
                if (model_valid) begin
                    check("rand_order", 32'(rx_data), 32'(exp_q.pop_front()));
                    model_valid = 1'b0;
                end
                rx_ack = 1'b1;
                step(1);
                rx_ack = 1'b0;
                check("rand_ack", 32'(rx_valid), 32'(model_valid));
            end
            step($urandom_range(0, 12));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, 8N1, LSB first.
- Sits directly downstream of the transmitter and consumes its txd line. On-chip loopback connects transmitter txd to this block's rxd.
- Uses 16x oversampling with majority-vote bit decisions, start-bit validation, framing/overrun error flags, and a one-entry holding register with a valid/ack handshake.

Parameters:
- CLKS_PER_SAMPLE, 2, clk cycles per oversample tick. 2 x 16 = 32 clk per bit, matching the transmitter baud at 100 MHz.
- OVERSAMPLE, 16, samples per bit. Fixed at 16; a different value is illegal.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-low reset
- rxd  input  1  serial line, idle high, asynchronous to clk
- rx_ack  input  1  consumer has taken rx_data; clears rx_valid
- rx_data  output  8  last good received byte
- rx_valid  output  1  level; rx_data holds an unread byte
- rx_busy  output  1  high while a frame is being received (state != IDLE)
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- overrun_err  output  1  one-cycle pulse; byte completed while rx_valid still high

Behaviour:
- Reset values (rst low, asynchronous): rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0, state=IDLE, synchronizer flops=1, all counters=0.
- rxd passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Tick generator: counts 0..CLKS_PER_SAMPLE-1 and emits a one-cycle tick on wrap. It runs only outside IDLE and is cleared on entry to START.
- Sample counter: counts 0..15 per bit on ticks. Samples are captured at counts 7, 8 and 9. The bit value is the 2-of-3 majority, decided on the tick at count 9.
- IDLE: a falling edge on rxs (prev 1, now 0) moves the state to START. rx_busy rises the following cycle.
- START: at the decision point, majority 1 is a false start: return to IDLE with no flags. Majority 0 moves to DATA with bit index 0.
- DATA: each decision shifts the bit into the shift register, LSB first. After bit index 7, go to STOP.
- STOP, at the decision point, one of three outcomes:
  - majority 1 and rx_valid=0: load rx_data, set rx_valid.
  - majority 1 and rx_valid=1: keep the old rx_data, pulse overrun_err, drop the new byte.
  - majority 0: pulse frame_err, discard the byte, rx_valid unchanged.
- STOP then returns to IDLE in all three cases. The return happens at mid-stop-bit, so a back-to-back frame's start edge is caught.
- After a break (line held low), IDLE needs rxs to return high before a new falling edge can be detected.
- Latency: the stop decision comes (9*16+9)*CLKS_PER_SAMPLE = 306 clk after the cycle the rxs falling edge is detected. rx_valid, frame_err and overrun_err assert on the next clock edge (307).
- Handshake: rx_ack with rx_valid=1 clears rx_valid next cycle. rx_ack with rx_valid=0 is ignored.
- If rx_ack and a new good byte land in the same cycle, the ack clears the old byte and the new byte loads: rx_valid stays 1, no overrun.
- Reset asserted mid-frame aborts immediately to the reset values above. After release, the block waits for a fresh falling edge; it never resumes a partial frame.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP), 2-bit encoding;
  - OVERSAMPLE=16, DATA_BITS=8, SAMPLE_LO/MID/HI=7/8/9.
- The transmitter also uses uart_pkg for DATA_BITS.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with reset value 1 and a falling-edge detect output.

Test Plan:
- Loopback transmitter->receiver, send 0xA5 → rx_valid rises 307 clk after the detected start edge, rx_data=0xA5, frame_err=0. Then pulse rx_ack → rx_valid=0.
- 0xA5 then 0x3C back-to-back (tran_start on the cycle tx_busy falls), rx_ack after each → both bytes received in order, no errors.
- rxd glitch low for 6 clk then high → rx_busy pulses, no valid, no errors, block back in IDLE within 20 clk.
- Frame 0x55 with stop bit forced 0 → frame_err one-cycle pulse at stop decision, rx_valid stays 0, rx_data unchanged.
- Send 0x11 without ack, then 0x22 → overrun_err pulse, rx_data remains 0x11, rx_valid stays 1.
- Assert rst at bit 4 of a frame, release, send 0x3C → outputs reset immediately, no partial byte, then rx_data=0x3C.
